// File: rtl/stream_sequencer_pkg.sv
// Shared types and constants for the descriptor sequencer and its FIFO.
// No logic: FSM states, CSR maps for both bus sides, descriptor layout.
// The reader's busy flag lives at bit 1 of its CTRL/STATUS word.
package stream_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WR_PTR,
        ST_WR_CNT,
        ST_WR_GO,
        ST_SETTLE,
        ST_POLL,
        ST_POLL_CHK,
        ST_DONE
    } seq_state_t;

    // Slave (CPU-facing) word addresses
    localparam logic [3:0] S_CTRL       = 4'd0;
    localparam logic [3:0] S_PTR        = 4'd1;
    localparam logic [3:0] S_COUNT      = 4'd2;
    localparam logic [3:0] S_DONE_COUNT = 4'd3;

    // Reader CSR word addresses
    localparam logic [3:0] R_CTRL  = 4'd0;
    localparam logic [3:0] R_PTR   = 4'd1;
    localparam logic [3:0] R_COUNT = 4'd2;

    localparam int READER_BUSY_BIT = 1;

    typedef struct packed {
        logic [31:0] ptr;
        logic [23:0] count;
    } desc_t;

endpackage

// File: rtl/stream_sequencer_desc_fifo.sv
// Descriptor FIFO: show-ahead head, push/pop, full/empty/level.
// Latency: push visible at head one cycle later; pop takes effect at the edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module desc_fifo
    import stream_sequencer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     clock_areset_n,
    input  logic                     push,
    input  desc_t                    push_dat,
    input  logic                     pop,
    output desc_t                    pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    desc_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push_ok;
    logic           pop_ok;

    assign full    = level == (AW+1)'(DEPTH);
    assign empty   = level == '0;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/stream_sequencer.sv
// Pops (ptr,count) descriptors and drives the reader's CSRs: PTR, COUNT, GO, poll busy.
// Latency: pop to first master write 2 cycles; ~SETTLE+8 cycles per descriptor minimum.
// Backpressure: slave reads take one wait state; master ops hold until m_waitrequest drops.
module stream_sequencer
    import stream_sequencer_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int SETTLE = 4
) (
    input  logic        clock,
    input  logic        clock_areset_n,
    input  logic [3:0]  s_address,
    output logic [31:0] s_readdata,
    input  logic [31:0] s_writedata,
    input  logic        s_read,
    input  logic        s_write,
    output logic        s_waitrequest,
    output logic [3:0]  m_address,
    output logic [31:0] m_writedata,
    output logic        m_read,
    output logic        m_write,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,
    output logic        irq
);
    localparam int LW = $clog2(DEPTH) + 1;

    seq_state_t     state;
    desc_t          cur_desc;
    desc_t          head_desc;
    desc_t          push_desc;
    logic           enable;
    logic           irq_enable;
    logic           overflow;
    logic           read_latency;
    logic           busy_q;
    logic [31:0]    ptr_stage;
    logic [15:0]    done_count;
    logic [3:0]     settle_cnt;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_push;
    logic           fifo_pop;
    logic [LW-1:0]  fifo_level;
    logic           ctrl_wr;
    logic           clr_done;
    logic           clr_irq;
    logic           m_ack;
    logic [31:0]    rd_mux;
    logic           unused_rd_bits;

    assign ctrl_wr        = s_write && (s_address == S_CTRL);
    assign clr_done       = ctrl_wr && s_writedata[1];
    assign clr_irq        = ctrl_wr && s_writedata[2];
    assign fifo_push      = s_write && (s_address == S_COUNT);
    assign push_desc      = '{ptr: ptr_stage, count: s_writedata[23:0]};
    assign fifo_pop       = (state == ST_IDLE) && enable && !fifo_empty;
    assign m_ack          = (m_write || m_read) && !m_waitrequest;
    assign s_waitrequest  = s_read && !read_latency;
    assign unused_rd_bits = ^{m_readdata[31:READER_BUSY_BIT+1], m_readdata[READER_BUSY_BIT-1:0]};

    desc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock          (clock),
        .clock_areset_n (clock_areset_n),
        .push           (fifo_push),
        .push_dat       (push_desc),
        .pop            (fifo_pop),
        .pop_dat        (head_desc),
        .full           (fifo_full),
        .empty          (fifo_empty),
        .level          (fifo_level)
    );

    always_comb begin
        rd_mux = '0;
        case (s_address)
            S_CTRL: begin
                rd_mux[0]       = enable;
                rd_mux[1]       = state != ST_IDLE;
                rd_mux[2]       = fifo_empty;
                rd_mux[3]       = fifo_full;
                rd_mux[4]       = overflow;
                rd_mux[5]       = irq;
                rd_mux[8 +: LW] = fifo_level;
                rd_mux[16]      = irq_enable;
            end
            S_PTR:        rd_mux = ptr_stage;
            S_DONE_COUNT: rd_mux = {16'h0, done_count};
            default:      rd_mux = '0;
        endcase
    end

    // CPU-side CSRs; clears take priority over same-cycle completion updates
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            read_latency <= 1'b0;
            s_readdata   <= '0;
            enable       <= 1'b0;
            irq_enable   <= 1'b0;
            ptr_stage    <= '0;
            overflow     <= 1'b0;
            done_count   <= '0;
            irq          <= 1'b0;
        end else begin
            if (s_read && !read_latency) begin
                read_latency <= 1'b1;
                s_readdata   <= rd_mux;
            end else begin
                read_latency <= 1'b0;
            end
            if (ctrl_wr) begin
                enable     <= s_writedata[0];
                irq_enable <= s_writedata[3];
            end
            if (s_write && (s_address == S_PTR)) ptr_stage <= s_writedata;
            if (clr_irq)                                       overflow <= 1'b0;
            else if (fifo_push && fifo_full && !fifo_pop)      overflow <= 1'b1;
            if (clr_done)                                      done_count <= '0;
            else if (state == ST_DONE && done_count != 16'hFFFF) done_count <= done_count + 16'd1;
            if (clr_irq)                                       irq <= 1'b0;
            else if (state == ST_DONE && irq_enable)           irq <= 1'b1;
        end
    end

    // Master strobes are loaded on the transition into each op state, so
    // consecutive CSR writes go back to back with no idle cycle between them.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            state       <= ST_IDLE;
            cur_desc    <= '0;
            m_address   <= '0;
            m_writedata <= '0;
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            settle_cnt  <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        cur_desc <= head_desc;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (cur_desc.count == '0) begin
                        state <= ST_DONE;
                    end else begin
                        m_address   <= R_PTR;
                        m_writedata <= cur_desc.ptr;
                        m_write     <= 1'b1;
                        state       <= ST_WR_PTR;
                    end
                end
                ST_WR_PTR: begin
                    if (m_ack) begin
                        m_address   <= R_COUNT;
                        m_writedata <= {8'h0, cur_desc.count};
                        state       <= ST_WR_CNT;
                    end
                end
                ST_WR_CNT: begin
                    if (m_ack) begin
                        m_address   <= R_CTRL;
                        m_writedata <= 32'h1;
                        state       <= ST_WR_GO;
                    end
                end
                ST_WR_GO: begin
                    if (m_ack) begin
                        m_write     <= 1'b0;
                        m_writedata <= '0;
                        settle_cnt  <= 4'(SETTLE - 1);
                        state       <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        m_address <= R_CTRL;
                        m_read    <= 1'b1;
                        state     <= ST_POLL;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                ST_POLL: begin
                    if (m_ack) begin
                        m_read <= 1'b0;
                        busy_q <= m_readdata[READER_BUSY_BIT];
                        state  <= ST_POLL_CHK;
                    end
                end
                ST_POLL_CHK: begin
                    if (busy_q) begin
                        m_read <= 1'b1;
                        state  <= ST_POLL;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_sequencer.sv
// Directed bench: CPU-side CSR tasks plus a behavioural reader target with
// programmable busy time and COUNT-write stall; checks via immediate assertions.
module tb_stream_sequencer;

    logic        clock;
    logic        clock_areset_n;
    logic [3:0]  s_address;
    logic [31:0] s_readdata;
    logic [31:0] s_writedata;
    logic        s_read;
    logic        s_write;
    logic        s_waitrequest;
    logic [3:0]  m_address;
    logic [31:0] m_writedata;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_readdata;
    logic        m_waitrequest;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // reader target model
    int busy_cfg   = 0;
    int busy_left  = 0;
    int stall_cfg  = 0;
    int stall_done = 0;
    int stall_seen = 0;
    int stall_bad  = 0;
    int nreads     = 0;
    logic [3:0]  log_a [$];
    logic [31:0] log_d [$];
    logic [3:0]  exp_a [$];
    logic [31:0] exp_d [$];

    stream_sequencer #(.DEPTH(8), .SETTLE(4)) dut (
        .clock          (clock),
        .clock_areset_n (clock_areset_n),
        .s_address      (s_address),
        .s_readdata     (s_readdata),
        .s_writedata    (s_writedata),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_waitrequest  (s_waitrequest),
        .m_address      (m_address),
        .m_writedata    (m_writedata),
        .m_read         (m_read),
        .m_write        (m_write),
        .m_readdata     (m_readdata),
        .m_waitrequest  (m_waitrequest),
        .irq            (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign m_waitrequest = m_write && (m_address == 4'd2) && (stall_done < stall_cfg);
    assign m_readdata    = {30'h0, (busy_left != 0), 1'b0};

    always @(posedge clock) begin
        if (m_write && !m_waitrequest) begin
            log_a.push_back(m_address);
            log_d.push_back(m_writedata);
            if (m_address == 4'd0 && m_writedata[0]) busy_left <= busy_cfg;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
        end
        if (m_read && !m_waitrequest) nreads <= nreads + 1;
        if (m_waitrequest) stall_done <= stall_done + 1;
    end

    always @(negedge clock) begin
        if (m_waitrequest) begin
            stall_seen = stall_seen + 1;
            if (m_address !== 4'd2 || m_writedata !== 32'h55 || m_write !== 1'b1)
                stall_bad = stall_bad + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        s_address   = a;
        s_writedata = d;
        s_write     = 1'b1;
        @(negedge clock);
        s_write     = 1'b0;
    endtask

    task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
        bit got;
        got       = 1'b0;
        d         = '0;
        s_address = a;
        s_read    = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            if (!s_waitrequest) begin
                d   = s_readdata;
                got = 1'b1;
            end
        end
        @(negedge clock);
        s_read = 1'b0;
        if (!got) chk("slave_read_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] st;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            csr_read(4'd0, st);
            if (st[2] && !st[1]) ok = 1'b1;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic check_log(input string tag);
        int n;
        chk({tag, "_len"}, log_a.size(), exp_a.size());
        n = (log_a.size() < exp_a.size()) ? log_a.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 32'(log_a[i]), 32'(exp_a[i]));
            chk($sformatf("%s_data%0d", tag, i), log_d[i], exp_d[i]);
        end
        log_a.delete(); log_d.delete();
        exp_a.delete(); exp_d.delete();
    endtask

    task automatic expect_desc(input logic [31:0] p, input logic [31:0] c);
        exp_a.push_back(4'd1); exp_d.push_back(p);
        exp_a.push_back(4'd2); exp_d.push_back(c);
        exp_a.push_back(4'd0); exp_d.push_back(32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int rbase;
        int sbase;
        bit hit;

        s_address = '0; s_writedata = '0; s_read = 1'b0; s_write = 1'b0;
        clock_areset_n = 1'b1;
        #3 clock_areset_n = 1'b0;
        #2;
        chk("rst_m_read", 32'(m_read), 32'd0);
        chk("rst_m_write", 32'(m_write), 32'd0);
        chk("rst_m_address", 32'(m_address), 32'd0);
        chk("rst_m_writedata", m_writedata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_s_readdata", s_readdata, 32'd0);
        chk("rst_s_waitrequest", 32'(s_waitrequest), 32'd0);
        @(negedge clock);
        clock_areset_n = 1'b1;
        @(negedge clock);
        csr_read(4'd0, rd);  chk("rst_status", rd, 32'h4);
        csr_read(4'd3, rd);  chk("rst_done_count", rd, 32'd0);

        // single descriptor
        busy_cfg = 10;
        rbase = nreads;
        csr_write(4'd1, 32'h1000);
        csr_write(4'd2, 32'd16);
        csr_read(4'd1, rd);  chk("t1_ptr_readback", rd, 32'h1000);
        csr_read(4'd0, rd);  chk("t1_status_queued", rd, 32'h100);
        csr_write(4'd0, 32'h1);
        wait_idle("t1_idle");
        expect_desc(32'h1000, 32'd16);
        check_log("t1_log");
        chk("t1_polled_twice", 32'((nreads - rbase) >= 2), 32'd1);
        csr_read(4'd3, rd);  chk("t1_done_count", rd, 32'd1);

        // three queued descriptors, long busy
        csr_write(4'd0, 32'h3);
        csr_read(4'd3, rd);  chk("t2_dc_cleared", rd, 32'd0);
        busy_cfg = 20;
        for (int i = 0; i < 3; i++) begin
            csr_write(4'd1, 32'hA000 + 32'(i));
            csr_write(4'd2, 32'(i + 1));
            expect_desc(32'hA000 + 32'(i), 32'(i + 1));
        end
        wait_idle("t2_idle");
        check_log("t2_log");
        csr_read(4'd3, rd);  chk("t2_done_count", rd, 32'd3);
        csr_read(4'd0, rd);  chk("t2_status", rd, 32'h5);

        // overflow while disabled
        csr_write(4'd0, 32'h0);
        for (int i = 0; i < 9; i++) begin
            csr_write(4'd1, 32'h5000 + 32'(i));
            csr_write(4'd2, 32'(i + 1));
        end
        csr_read(4'd0, rd);  chk("t3_status_ovf", rd, 32'h818);
        csr_write(4'd0, 32'h4);
        csr_read(4'd0, rd);  chk("t3_status_clr", rd, 32'h808);
        busy_cfg = 0;
        csr_write(4'd0, 32'h1);
        wait_idle("t3_drain");
        chk("t3_drained_writes", log_a.size(), 32'd24);
        log_a.delete(); log_d.delete();
        csr_read(4'd3, rd);  chk("t3_done_count", rd, 32'd11);

        // five-cycle stall on the COUNT write
        sbase = stall_seen;
        stall_cfg = stall_done + 5;
        csr_write(4'd1, 32'h2000);
        csr_write(4'd2, 32'h55);
        wait_idle("t4_idle");
        chk("t4_stall_cycles", 32'(stall_seen - sbase), 32'd5);
        chk("t4_stall_unstable", 32'(stall_bad), 32'd0);
        expect_desc(32'h2000, 32'h55);
        check_log("t4_log");

        // zero-count descriptor with interrupt
        csr_write(4'd0, 32'h9);
        rbase = nreads;
        csr_write(4'd1, 32'h3000);
        csr_write(4'd2, 32'd0);
        wait_idle("t5_idle");
        check_log("t5_log");
        chk("t5_no_reads", 32'(nreads - rbase), 32'd0);
        csr_read(4'd3, rd);  chk("t5_done_count", rd, 32'd13);
        chk("t5_irq_set", 32'(irq), 32'd1);
        csr_read(4'd0, rd);  chk("t5_status", rd, 32'h10025);
        csr_write(4'd0, 32'hD);
        chk("t5_irq_cleared", 32'(irq), 32'd0);

        // DONE_COUNT clear landing on the DONE cycle
        csr_write(4'd1, 32'h3100);
        csr_write(4'd2, 32'd0);
        @(negedge clock);
        @(negedge clock);
        csr_write(4'd0, 32'hB);
        wait_idle("t6_idle");
        csr_read(4'd3, rd);  chk("t6_clear_wins", rd, 32'd0);
        chk("t6_irq_set", 32'(irq), 32'd1);

        // async reset during POLL
        csr_write(4'd0, 32'h1);
        busy_cfg = 50;
        csr_write(4'd1, 32'h4000);
        csr_write(4'd2, 32'd8);
        csr_write(4'd1, 32'h4100);
        csr_write(4'd2, 32'd8);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clock);
            if (m_read) hit = 1'b1;
        end
        chk("t7_reached_poll", 32'(hit), 32'd1);
        #2 clock_areset_n = 1'b0;
        #1;
        chk("t7_m_read_async", 32'(m_read), 32'd0);
        chk("t7_m_write", 32'(m_write), 32'd0);
        chk("t7_irq", 32'(irq), 32'd0);
        @(negedge clock);
        clock_areset_n = 1'b1;
        @(negedge clock);
        csr_read(4'd0, rd);  chk("t7_status", rd, 32'h4);
        csr_read(4'd3, rd);  chk("t7_done_count", rd, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
